// File: rtl/mdu_ctrl_pkg.sv
// Shared MD op codes, FSM state type and helpers for the multiply/divide controller.
// The MADD/MSUB codes are always defined; they decode only when MDU_MADD_EN is set.
package mdu_ctrl_pkg;

  typedef enum logic {
    StIdle,
    StRun
  } mdu_state_e;

  localparam logic [3:0] MDU_MULT  = 4'd0;
  localparam logic [3:0] MDU_MULTU = 4'd1;
  localparam logic [3:0] MDU_DIV   = 4'd2;
  localparam logic [3:0] MDU_DIVU  = 4'd3;
  localparam logic [3:0] MDU_MTHI  = 4'd4;
  localparam logic [3:0] MDU_MTLO  = 4'd5;
  localparam logic [3:0] MDU_MADD  = 4'd6;
  localparam logic [3:0] MDU_MADDU = 4'd7;
  localparam logic [3:0] MDU_MSUB  = 4'd8;
  localparam logic [3:0] MDU_MSUBU = 4'd9;

  function automatic logic is_signed_op(logic [3:0] op);
    return op inside {MDU_MULT, MDU_DIV, MDU_MADD, MDU_MSUB};
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Issue/result bundle between the EX stage and the MD controller.
interface mdu_ctrl_if;
  logic [31:0] MDU_i_Operand1;
  logic [31:0] MDU_i_Operand2;
  logic [3:0]  MDU_i_Operation;
  logic        MDU_i_start;
  logic        MDU_o_busy;
  logic [31:0] MDU_o_HI;
  logic [31:0] MDU_o_LO;

  modport master (
    output MDU_i_Operand1, MDU_i_Operand2, MDU_i_Operation, MDU_i_start,
    input  MDU_o_busy, MDU_o_HI, MDU_o_LO
  );

  modport slave (
    input  MDU_i_Operand1, MDU_i_Operand2, MDU_i_Operation, MDU_i_start,
    output MDU_o_busy, MDU_o_HI, MDU_o_LO
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle MD controller owning HI/LO: result computed at start, committed after a fixed count.
// Define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU accumulate ops.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_ctrl_if.slave bus
);

  localparam int unsigned CntMax = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  mdu_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [31:0]       phi_q, phi_d, plo_q, plo_d;

  logic              sgn;
  logic              div_zero;
  logic signed [63:0] a_ext, b_ext, b_div;
  logic [63:0]       prod;
  logic [31:0]       quot, rem;

  // 64-bit extended operands keep the DIV 0x80000000 / -1 case in range (quotient wraps to LO).
  always_comb begin
    sgn      = is_signed_op(bus.MDU_i_Operation);
    a_ext    = $signed({{32{sgn & bus.MDU_i_Operand1[31]}}, bus.MDU_i_Operand1});
    b_ext    = $signed({{32{sgn & bus.MDU_i_Operand2[31]}}, bus.MDU_i_Operand2});
    div_zero = (bus.MDU_i_Operand2 == '0);
    b_div    = div_zero ? 64'sd1 : b_ext;
    prod     = a_ext * b_ext;
    quot     = 32'(a_ext / b_div);
    rem      = 32'(a_ext % b_div);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;

    unique case (state_q)
      StIdle: begin
        if (bus.MDU_i_start) begin
          case (bus.MDU_i_Operation)
            MDU_MULT, MDU_MULTU: begin
              {phi_d, plo_d} = prod;
              cnt_d          = CntW'(MULT_CYCLES);
              state_d        = StRun;
            end
            MDU_DIV, MDU_DIVU: begin
              {phi_d, plo_d} = div_zero ? {hi_q, lo_q} : {rem, quot};
              cnt_d          = CntW'(DIV_CYCLES);
              state_d        = StRun;
            end
            MDU_MTHI: hi_d = bus.MDU_i_Operand1;
            MDU_MTLO: lo_d = bus.MDU_i_Operand1;
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU: begin
              {phi_d, plo_d} = {hi_q, lo_q} + prod;
              cnt_d          = CntW'(MULT_CYCLES);
              state_d        = StRun;
            end
            MDU_MSUB, MDU_MSUBU: begin
              {phi_d, plo_d} = {hi_q, lo_q} - prod;
              cnt_d          = CntW'(MULT_CYCLES);
              state_d        = StRun;
            end
`endif
            default: ;
          endcase
        end
      end
      StRun: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          hi_d    = phi_q;
          lo_d    = plo_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
    end
  end

  assign bus.MDU_o_busy = (state_q == StRun);
  assign bus.MDU_o_HI   = hi_q;
  assign bus.MDU_o_LO   = lo_q;

endmodule
